irq_controller: RTL and testbench

Platform interrupt source for the 3-stage RISC-V core: owns a free-running machine timer (mtime/mtimecmp), latches edge-triggered external interrupt lines, arbitrates pending sources, and presents a single `interrupt`/`intr_cause` request to the CSR register file. The request is held until the core acknowledges trap entry. Software configures the block through a small word-addressed register port on the data bus.

---
 rtl/irq_controller.sv | 89 ++++++++
 tb/tb_irq_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: machine timer, edge-latched external lines and a held single-request arbiter
module irq_controller #(
  parameter int N_EXT = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic             irq_ack,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [3:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             interrupt,
  output logic [31:0]      intr_cause
);
  localparam int W = N_EXT + 1;
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state, state_n;
  logic [31:0] pre, mtime, mtimecmp, rd;
  logic [W-1:0] en, pend, act, set, clr;
  logic [N_EXT-1:0] s1, s2, prev;
  logic [1:0] primed;
  logic [3:0] win, gnt;
  logic tcmp, tcmp_q, wrap, any, wr_time, wr_cmp, wr_en, wr_pend, unused_addr;
  assign unused_addr = ^bus_addr[1:0];
  assign wr_time = bus_we && bus_addr[3:2] == 2'd0;
  assign wr_cmp = bus_we && bus_addr[3:2] == 2'd1;
  assign wr_en = bus_we && bus_addr[3:2] == 2'd2;
  assign wr_pend = bus_we && bus_addr[3:2] == 2'd3;
  assign wrap = pre == 32'(PRESCALE - 1);
  assign tcmp = mtime >= mtimecmp;
  assign act = pend & en;
  assign any = |act;
  assign interrupt = state == REQ;
  // prev starts high and is frozen until the synchronizers hold real samples, so a line held through reset is not an edge
  assign set = {s2 & ~prev & {N_EXT{primed[1]}}, tcmp & ~tcmp_q};
  assign clr = (wr_pend ? bus_wdata[W-1:0] : '0)
             | ((state == REQ && irq_ack) ? (W'(1) << gnt) : '0)
             | {{N_EXT{1'b0}}, wr_cmp};
  assign rd = bus_addr[3:2] == 2'd0 ? mtime :
              bus_addr[3:2] == 2'd1 ? mtimecmp :
              bus_addr[3:2] == 2'd2 ? 32'(en) : 32'(pend);
  // bit 0 (timer) is the fallback; lower external indices override higher ones
  always_comb begin
    win = 4'd0;
    for (int i = W - 1; i >= 1; i--) if (act[i]) win = 4'(i);
  end
  always_comb begin
    state_n = state == IDLE ? (any ? REQ : IDLE) :
              state == REQ ? (irq_ack ? GAP : REQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre <= '0;
      mtime <= '0;
      mtimecmp <= '1;
      en <= '0;
      pend <= '0;
      tcmp_q <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      prev <= '1;
      primed <= '0;
      gnt <= '0;
      intr_cause <= '0;
      bus_rdata <= '0;
    end else begin
      state <= state_n;
      pre <= (wr_time || wrap) ? '0 : pre + 32'd1;
      mtime <= wr_time ? bus_wdata : wrap ? mtime + 32'd1 : mtime;
      mtimecmp <= wr_cmp ? bus_wdata : mtimecmp;
      en <= wr_en ? bus_wdata[W-1:0] : en;
      pend <= (pend & ~clr) | set;
      tcmp_q <= tcmp && !wr_cmp;
      s1 <= ext_irq;
      s2 <= s1;
      primed <= {primed[0], 1'b1};
      prev <= primed[1] ? s2 : prev;
      if (state == IDLE && any) begin
        gnt <= win;
        intr_cause <= win == 4'd0 ? 32'h8000_0007 : 32'h8000_000F + 32'(win);
      end
      if (bus_re) bus_rdata <= rd;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: randomized scenarios, expected requests/reads queued at issue time and checked by a monitor
module tb_irq_controller;
  localparam int N_EXT = 4;
  typedef struct {
    logic [31:0] cause;
    int          rdy;
  } req_t;
  logic clk = 0, rst = 1, irq_ack = 0, bus_we = 0, bus_re = 0, interrupt;
  logic [N_EXT-1:0] ext_irq = '0;
  logic [3:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0, bus_rdata, intr_cause;
  req_t irq_q[$];
  req_t e_mon;
  logic [31:0] rd_q[$];
  logic [31:0] cur_exp = '0;
  logic int_prev = 0, rd_now = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, last_ack = -100, last_wr = 0;

  irq_controller #(.N_EXT(N_EXT), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .irq_ack(irq_ack),
    .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .interrupt(interrupt), .intr_cause(intr_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: read data one cycle after bus_re, interrupt rise time/cause, and cause stability while requesting
  always @(posedge clk) begin
    cyc++;
    rd_now = bus_re;
    #1;
    if (rd_now) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL read_unexpected: data 0x%08h with no read queued", bus_rdata);
      end else chk("rdata", bus_rdata, rd_q.pop_front());
    end
    if (interrupt && !int_prev) begin
      if (irq_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL irq_unexpected: cause 0x%08h at cycle %0d, no request expected", intr_cause, cyc);
      end else begin
        e_mon = irq_q.pop_front();
        cur_exp = e_mon.cause;
        chk("irq_cause", intr_cause, e_mon.cause);
        chk("irq_cycle", cyc, (e_mon.rdy > last_ack + 2) ? e_mon.rdy : last_ack + 2);
      end
    end else if (interrupt) chk("cause_held", intr_cause, cur_exp);
    int_prev = interrupt;
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_we = 1; bus_addr = {a, 2'b00}; bus_wdata = d; last_wr = cyc + 1;
    @(negedge clk);
    bus_we = 0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    bus_re = 1; bus_addr = {a, 2'b00}; rd_q.push_back(exp);
    @(negedge clk);
    bus_re = 0;
  endtask

  task automatic expect_irq(input logic [31:0] cause, input int rdy);
    req_t e;
    e.cause = cause; e.rdy = rdy;
    irq_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!interrupt && n < 300) begin @(negedge clk); n++; end
    if (!interrupt) begin
      n_chk++; n_fail++;
      $display("FAIL irq_timeout: interrupt 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic ack();
    irq_ack = 1; last_ack = cyc + 1;
    @(negedge clk);
    irq_ack = 0;
    chk("irq_low_after_ack", {31'd0, interrupt}, 32'd0);
  endtask

  task automatic reset_checks(input int r);
    chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
    chk("rst_cause", intr_cause, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    rd(2'd0, 32'(cyc - r));
    rd(2'd1, 32'hFFFF_FFFF);
    rd(2'd2, 32'd0);
    rd(2'd3, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, cval, i, j, hi, lo, r;
    repeat (3) @(negedge clk);
    rst = 0; r = cyc;
    reset_checks(r);
    // timer compare and no re-fire while mtime stays above mtimecmp
    cval = $urandom_range(20, 60);
    wr(2'd0, 32'd0);
    wr(2'd1, 32'(cval));
    wr(2'd2, 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd0, 32'd0); w = last_wr;
    expect_irq(32'h8000_0007, w + cval + 2);
    wait_irq(); idle(3); ack();
    rd(2'd3, 32'd0);
    idle(30);
    rd(2'd0, 32'(cyc - w));
    rd(2'd1, 32'(cval));
    // lowering mtimecmp below mtime re-arms the compare; then wrap-around gives a fresh match
    wr(2'd1, 32'd5); w = last_wr;
    expect_irq(32'h8000_0007, w + 2);
    wait_irq(); ack();
    wr(2'd0, 32'hFFFF_FFF0); w = last_wr;
    expect_irq(32'h8000_0007, w + 16 + 5 + 2);
    wait_irq(); ack();
    // external arbitration and request holding
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h1F);
    for (int k = 0; k < 5; k++) begin
      i = (k == 0) ? 0 : $urandom_range(0, 2);
      j = (k == 0) ? 2 : $urandom_range(i + 1, 3);
      ext_irq = 4'(1 << i) | 4'(1 << j);
      expect_irq(32'h8000_0010 + 32'(i), cyc + 4);
      expect_irq(32'h8000_0010 + 32'(j), cyc + 4);
      wait_irq(); idle(2); ack(); wait_irq(); ack();
      ext_irq = '0; idle(4);
      hi = (k == 0) ? 3 : $urandom_range(1, 3);
      lo = (k == 0) ? 0 : $urandom_range(0, hi - 1);
      ext_irq = 4'(1 << hi);
      expect_irq(32'h8000_0010 + 32'(hi), cyc + 4);
      wait_irq();
      ext_irq = ext_irq | 4'(1 << lo);
      expect_irq(32'h8000_0010 + 32'(lo), cyc + 4);
      idle(6); ack(); wait_irq(); ack();
      ext_irq = '0; idle(4);
    end
    // disabled source stays pending, W1C clears it, W1C racing a new edge loses
    wr(2'd2, 32'd0);
    ext_irq = 4'b0010; idle(6);
    rd(2'd3, 32'h4);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'd0);
    ext_irq = '0; idle(4);
    ext_irq = 4'b0010; idle(2);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4);
    wr(2'd3, 32'h1F);
    rd(2'd3, 32'd0);
    ext_irq = '0; idle(4);
    // reset during a request; a line held across reset gives no event until it toggles
    wr(2'd2, 32'h1F);
    ext_irq = 4'b0100;
    expect_irq(32'h8000_0012, cyc + 4);
    wait_irq(); idle(1);
    rst = 1; @(negedge clk); rst = 0; r = cyc;
    reset_checks(r);
    wr(2'd2, 32'h1F); idle(10);
    rd(2'd3, 32'd0);
    ext_irq = '0; idle(4);
    ext_irq = 4'b0100;
    expect_irq(32'h8000_0012, cyc + 4);
    wait_irq(); ack();
    ext_irq = '0; idle(5);
    chk("irq_queue_empty", 32'(irq_q.size()), 32'd0);
    chk("read_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
